// File: rtl/noc_arb_pkg.sv
// Shared types and defaults for the NoC round-robin output arbiter.
package noc_arb_pkg;

   localparam int unsigned ARB_NUM_PORTS = 5;
   localparam int unsigned ARB_MAX_HOLD  = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   // Width of a binary port index; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      if (n > 2) return $clog2(n);
      else       return 1;
   endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational rotate-priority finder: first set req bit at or after start, with wrap.
module noc_rr_pick #(
   parameter int unsigned N = 5,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [W-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = W'((32'(start) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter with sticky ownership and rts/dcts flit handshake.
// Optional hold limit on consecutive wins is enabled by defining NOC_ARB_HOLD_LIMIT_EN.
module noc_rr_arbiter
   import noc_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS = ARB_NUM_PORTS,
   parameter int unsigned MAX_HOLD  = ARB_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 dcts,
   output logic                 rts,
   output logic [NUM_PORTS-1:0] grant,
   output logic [NUM_PORTS-1:0] xbar_sel
);

   localparam int unsigned   IW       = idx_w(NUM_PORTS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PORTS - 1);

   if (NUM_PORTS < 2 || NUM_PORTS > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
      $error("noc_rr_arbiter: NUM_PORTS must be 2..16 and MAX_HOLD 1..255");
   end

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
      return (x == LAST_IDX) ? '0 : x + 1'b1;
   endfunction

   arb_state_e           state, state_n;
   logic                 rts_n;
   logic [IW-1:0]        owner, owner_n;
   logic [IW-1:0]        ptr, ptr_n;
   logic                 fresh, fresh_n;
   logic [IW-1:0]        start_idx;
   logic                 pick_found;
   logic [IW-1:0]        pick_idx;
   logic [NUM_PORTS-1:0] owner_oh;

`ifdef NOC_ARB_HOLD_LIMIT_EN
   localparam int unsigned   HW       = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   logic [HW-1:0] hold, hold_n;
`endif

   assign owner_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner;
   assign xbar_sel = (state == ST_OWN) ? owner_oh : '0;
   assign grant    = xbar_sel & {NUM_PORTS{rts & dcts & ~rst}};

   // Search origin: after the last owner when idle, the owner itself while owning.
   always_comb begin
      if (state == ST_IDLE) start_idx = wrap_inc(ptr);
      else                  start_idx = owner;
`ifdef NOC_ARB_HOLD_LIMIT_EN
      if (state == ST_OWN && hold == HOLD_MAX && |(req & ~owner_oh))
         start_idx = wrap_inc(owner);
`endif
   end

   noc_rr_pick #(
      .N (NUM_PORTS),
      .W (IW)
   ) u_pick (
      .req   (req),
      .start (start_idx),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Next state: the first OWN cycle only raises rts; later gap cycles re-arbitrate.
   always_comb begin
      state_n = state;
      rts_n   = rts;
      owner_n = owner;
      ptr_n   = ptr;
      fresh_n = fresh;
`ifdef NOC_ARB_HOLD_LIMIT_EN
      hold_n  = hold;
`endif
      case (state)
         ST_IDLE: begin
            rts_n = 1'b0;
            if (pick_found) begin
               state_n = ST_OWN;
               owner_n = pick_idx;
               ptr_n   = pick_idx;
               fresh_n = 1'b1;
`ifdef NOC_ARB_HOLD_LIMIT_EN
               hold_n  = HW'(1);
`endif
            end
         end
         ST_OWN: begin
            if (rts) begin
               if (dcts) rts_n = 1'b0;
            end else if (fresh) begin
               rts_n   = 1'b1;
               fresh_n = 1'b0;
            end else if (!pick_found) begin
               state_n = ST_IDLE;
               ptr_n   = owner;
            end else begin
               rts_n = 1'b1;
               if (pick_idx != owner) begin
                  owner_n = pick_idx;
                  ptr_n   = pick_idx;
`ifdef NOC_ARB_HOLD_LIMIT_EN
                  hold_n  = HW'(1);
               end else if (hold != HOLD_MAX) begin
                  hold_n  = hold + 1'b1;
`endif
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            rts_n   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         rts   <= 1'b0;
         owner <= '0;
         ptr   <= LAST_IDX;
         fresh <= 1'b0;
      end else begin
         state <= state_n;
         rts   <= rts_n;
         owner <= owner_n;
         ptr   <= ptr_n;
         fresh <= fresh_n;
      end
   end

`ifdef NOC_ARB_HOLD_LIMIT_EN
   always_ff @(posedge clk) begin
      if (rst) hold <= '0;
      else     hold <= hold_n;
   end
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed scoreboard bench for noc_rr_arbiter (NUM_PORTS=5, MAX_HOLD=4).
module tb_noc_rr_arbiter;

   typedef struct {
      logic       rts;
      logic [4:0] xbar;
      logic [4:0] grant;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] req;
   logic       dcts;
   logic       rts;
   logic [4:0] grant;
   logic [4:0] xbar_sel;

   int   total  = 0;
   int   passed = 0;
   exp_t exp_q[$];

   noc_rr_arbiter #(
      .NUM_PORTS (5),
      .MAX_HOLD  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .dcts     (dcts),
      .rts      (rts),
      .grant    (grant),
      .xbar_sel (xbar_sel)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, total);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
   endtask

   // Pop the oldest expectation and compare it against the sampled outputs.
   task automatic check_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         total++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
         return;
      end
      e = exp_q.pop_front();
      chk($sformatf("%s.rts", e.tag), {4'b0, rts}, {4'b0, e.rts});
      chk($sformatf("%s.xbar_sel", e.tag), xbar_sel, e.xbar);
      chk($sformatf("%s.grant", e.tag), grant, e.grant);
   endtask

   // Drive one cycle of stimulus, push its expectation, sample 1 unit later.
   task automatic cyc(input logic [4:0] r, input logic d, input logic rs,
                      input logic e_rts, input logic [4:0] e_xbar,
                      input logic [4:0] e_grant, input string tag);
      exp_t e;
      @(negedge clk);
      req  = r;
      dcts = d;
      rst  = rs;
      e.rts   = e_rts;
      e.xbar  = e_xbar;
      e.grant = e_grant;
      e.tag   = tag;
      exp_q.push_back(e);
      #1;
      check_out();
   endtask

   // Owner during the hold-limit sequence: with the limit, port 3 takes flits 5..8.
   function automatic logic [4:0] c_owner(input int k);
`ifdef NOC_ARB_HOLD_LIMIT_EN
      if (k >= 10 && k <= 17) return 5'b01000;
`endif
      return 5'b00001;
   endfunction

   initial begin
      logic [4:0] o;
      logic [4:0] stall_req [5];
      stall_req[0] = 5'b11111;
      stall_req[1] = 5'b00000;
      stall_req[2] = 5'b01000;
      stall_req[3] = 5'b10001;
      stall_req[4] = 5'b00010;

      rst  = 1'b1;
      req  = 5'b0;
      dcts = 1'b0;
      repeat (2) @(posedge clk);
      cyc(5'b00000, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, "reset");

      // Two requesters after reset: port 1 wins, alternating flit/gap.
      cyc(5'b00110, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, "a_idle");
      cyc(5'b00110, 1'b1, 1'b0, 1'b0, 5'b00010, 5'b00000, "a_win");
      for (int k = 0; k < 3; k++) begin
         cyc(5'b00110, 1'b1, 1'b0, 1'b1, 5'b00010, 5'b00010, "a_flit");
         if (k < 2) cyc(5'b00110, 1'b1, 1'b0, 1'b0, 5'b00010, 5'b00000, "a_gap");
      end
      cyc(5'b00100, 1'b1, 1'b0, 1'b0, 5'b00010, 5'b00000, "a_handoff");

      // Downstream stall with changing req: everything held, grant on release.
      cyc(5'b00100, 1'b0, 1'b0, 1'b1, 5'b00100, 5'b00000, "b_stall");
      for (int k = 0; k < 5; k++)
         cyc(stall_req[k], 1'b0, 1'b0, 1'b1, 5'b00100, 5'b00000, "b_stall");
      cyc(5'b00000, 1'b1, 1'b0, 1'b1, 5'b00100, 5'b00100, "b_release");
      cyc(5'b00000, 1'b1, 1'b0, 1'b0, 5'b00100, 5'b00000, "b_gap");
      cyc(5'b00000, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, "b_idle");

      // Hold limit between ports 0 and 3.
      cyc(5'b01001, 1'b1, 1'b1, 1'b0, 5'b00000, 5'b00000, "c_rst");
      cyc(5'b01001, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, "c_idle");
      cyc(5'b01001, 1'b1, 1'b0, 1'b0, 5'b00001, 5'b00000, "c_win");
      for (int k = 2; k <= 18; k++) begin
         o = c_owner(k);
         if (k % 2 == 0) cyc(5'b01001, 1'b1, 1'b0, 1'b1, o, o, $sformatf("c_flit%0d", k));
         else            cyc(5'b01001, 1'b1, 1'b0, 1'b0, o, 5'b00000, $sformatf("c_gap%0d", k));
      end
      cyc(5'b10000, 1'b1, 1'b0, 1'b0, 5'b00001, 5'b00000, "c_to4");

      // Port 4 drains to idle, then wrap gives port 0 priority; reset aborts a transfer.
      cyc(5'b10000, 1'b1, 1'b0, 1'b1, 5'b10000, 5'b10000, "d_flit4");
      cyc(5'b00000, 1'b1, 1'b0, 1'b0, 5'b10000, 5'b00000, "d_drop");
      cyc(5'b10001, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, "d_idle");
      cyc(5'b10001, 1'b1, 1'b0, 1'b0, 5'b00001, 5'b00000, "d_wrap");
      cyc(5'b10001, 1'b1, 1'b1, 1'b1, 5'b00001, 5'b00000, "d_rst_abort");
      cyc(5'b10001, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, "d_after_rst");
      cyc(5'b10001, 1'b1, 1'b0, 1'b0, 5'b00001, 5'b00000, "d_rewin");
      cyc(5'b10001, 1'b1, 1'b0, 1'b1, 5'b00001, 5'b00001, "d_flit0");

      // Sole requester past the hold limit keeps ownership.
      for (int k = 8; k <= 21; k++) begin
         if (k % 2 == 0) cyc(5'b00001, 1'b1, 1'b0, 1'b0, 5'b00001, 5'b00000, $sformatf("e_gap%0d", k));
         else            cyc(5'b00001, 1'b1, 1'b0, 1'b1, 5'b00001, 5'b00001, $sformatf("e_flit%0d", k));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/noc_rr_arbiter.md
NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 5: number of requesting input ports, legal 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive flits one port may win while others request; legal 1..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NUM_PORTS  per-port request; bit i set means port i has a flit pending.
REQ-006 dcts  input  1  downstream clear-to-send.
REQ-007 rts  output  1  registered request-to-send to downstream.
REQ-008 grant  output  NUM_PORTS  one-hot per-port grant pulse, or zero.
REQ-009 xbar_sel  output  NUM_PORTS  one-hot crossbar select of the current owner; zero when idle.

Function
REQ-010 The FSM SHALL have states IDLE (no owner) and OWN (owner register valid).
REQ-011 rts SHALL be registered: next value 0 in IDLE; next value 0 when rts=1 and dcts=1 (handshake); otherwise next value 1 in OWN.
REQ-012 grant SHALL equal xbar_sel masked by (rts & dcts & !rst), combinationally, with zero latency to dcts.
REQ-013 While rts=1 and dcts=0, owner, hold count and rts SHALL stay unchanged regardless of req.
REQ-014 In IDLE with req nonzero, the winner SHALL be the first set bit searching upward with wrap from ptr+1; the FSM enters OWN with hold count 1, and rts rises the following cycle.
REQ-015 In IDLE with req all zero, the FSM SHALL stay in IDLE with xbar_sel=0.
REQ-016 In OWN with rts=0 (gap cycle), the FSM SHALL re-arbitrate from the req sampled that cycle: search starts at the owner (sticky), or at owner+1 when the hold limit is reached (REQ-024).
REQ-017 Re-arbitration yielding the same owner SHALL increment the hold count, saturating at MAX_HOLD; a new owner SHALL load hold count 1 and update ptr to the new owner.
REQ-018 Re-arbitration with req all zero SHALL return to IDLE; ptr keeps the last owner.
REQ-019 Consequently one flit per owner SHALL be transferable at most every two cycles; no handshake SHALL occur in the cycle in which the owner changes.
REQ-020 Owner changes SHALL take effect only in gap cycles, never while rts=1.

Reset
REQ-021 While rst=1 at a rising edge: state<=IDLE, rts<=0, owner<=0, hold count<=0, ptr<=NUM_PORTS-1 (so port 0 has highest priority first).
REQ-022 Reset asserted mid-transfer (rts=1) SHALL abort without a grant in the reset cycle; the transfer is re-arbitrated from IDLE after rst deasserts.
REQ-023 Outputs after reset: rts=0, grant=0, xbar_sel=0.

Configuration
REQ-024 Macro NOC_ARB_HOLD_LIMIT_EN defined: when hold count = MAX_HOLD and any other req bit is set in a gap cycle, the search SHALL start at owner+1; if only the owner requests, it keeps ownership and the count stays saturated.
REQ-025 Macro NOC_ARB_HOLD_LIMIT_EN undefined: ownership SHALL be purely sticky (search always starts at the owner); the hold counter and MAX_HOLD are unused and SHALL be removed.

Structure
REQ-026 Package noc_arb_pkg SHALL hold the FSM state enum, the default NUM_PORTS/MAX_HOLD constants and the owner-index width function.
REQ-027 Sub-module noc_rr_pick SHALL be a combinational rotate-priority finder: inputs req vector and start index; outputs found flag and winner index.
REQ-028 Owner SHALL be stored as a binary index; xbar_sel is decoded from it, gated by state==OWN.

Verification (NUM_PORTS=5, MAX_HOLD=4, macro defined unless noted)
REQ-029 Reset, then req=5'b00110, dcts=1 -> owner 1, xbar_sel=00010; rts high from cycle 2; grant=00010 in each rts cycle; rts alternates 1/0.
REQ-030 Owner 2, rts=1, dcts=0 for 6 cycles, with req changing -> rts, xbar_sel and grant=0 are held; the grant pulse is issued in the first dcts=1 cycle.
REQ-031 req=5'b01001 held, dcts=1 -> port 0 wins 4 flits, then port 3 wins 4, then port 0 again; with the macro undefined, port 0 wins indefinitely.
REQ-032 Owner 4 finishes, req drops to 0 -> IDLE with xbar_sel=0; then req=5'b10001 -> port 0 wins (ptr=4, wrap).
REQ-033 rst pulsed for 1 cycle while rts=1 and dcts=1 -> grant=0 in that cycle; next cycle rts=0, state IDLE, and port 0 has priority.
REQ-034 Only the owner requests past MAX_HOLD -> ownership retained with a continuous one-flit-per-two-cycles grant pattern.
